// File: rtl/vga_timing_generator.sv
// Two-axis VGA timer: synchronised pixel tick, x/y counters, registered sync/VideoOn decode.
// Optional VGA_TIMING_SHADOW_EN latches timing inputs at reset and at every frame end.
module vga_timing_generator #(
    parameter int XRES_BITS      = 10,
    parameter int YRES_BITS      = 10,
    parameter bit HSYNC_POLARITY = 1'b0,
    parameter bit VSYNC_POLARITY = 1'b0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 PixelClock,
    input  logic [XRES_BITS-1:0] HActive,
    input  logic [XRES_BITS-1:0] HFrontPorch,
    input  logic [XRES_BITS-1:0] HSynch,
    input  logic [XRES_BITS-1:0] HBackPorch,
    input  logic [YRES_BITS-1:0] VActive,
    input  logic [YRES_BITS-1:0] VFrontPorch,
    input  logic [YRES_BITS-1:0] VSynch,
    input  logic [YRES_BITS-1:0] VBackPorch,
    output logic [XRES_BITS-1:0] xposition,
    output logic [YRES_BITS-1:0] yposition,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 VideoOn,
    output logic                 PixelTick,
    output logic                 LineEnd,
    output logic                 FrameEnd
);

    localparam int XW = XRES_BITS + 1;
    localparam int YW = YRES_BITS + 1;

    logic [XRES_BITS-1:0] ha, hfp, hs, hbp;
    logic [YRES_BITS-1:0] va, vfp, vs, vbp;

    logic                 pclk_meta_q, pclk_sync_q, pclk_prev_q, tick_q;
    logic [XRES_BITS-1:0] x_q, x_d;
    logic [YRES_BITS-1:0] y_q, y_d;
    logic                 hsync_q, vsync_q, video_q;
    logic                 hs_act_d, vs_act_d, video_d;
    logic                 line_end, frame_end;

    logic [XW-1:0] h_total, h_last, hs_start, hs_end;
    logic [YW-1:0] v_total, v_last, vs_start, vs_end;

`ifdef VGA_TIMING_SHADOW_EN
    logic [XRES_BITS-1:0] ha_q, hfp_q, hs_q, hbp_q;
    logic [YRES_BITS-1:0] va_q, vfp_q, vs_q, vbp_q;

    always_ff @(posedge Clock) begin
        if (Reset || frame_end) begin
            ha_q  <= HActive;
            hfp_q <= HFrontPorch;
            hs_q  <= HSynch;
            hbp_q <= HBackPorch;
            va_q  <= VActive;
            vfp_q <= VFrontPorch;
            vs_q  <= VSynch;
            vbp_q <= VBackPorch;
        end
    end

    assign ha  = ha_q;
    assign hfp = hfp_q;
    assign hs  = hs_q;
    assign hbp = hbp_q;
    assign va  = va_q;
    assign vfp = vfp_q;
    assign vs  = vs_q;
    assign vbp = vbp_q;
`else
    assign ha  = HActive;
    assign hfp = HFrontPorch;
    assign hs  = HSynch;
    assign hbp = HBackPorch;
    assign va  = VActive;
    assign vfp = VFrontPorch;
    assign vs  = VSynch;
    assign vbp = VBackPorch;
`endif

    assign h_total  = {1'b0, ha} + {1'b0, hfp} + {1'b0, hs} + {1'b0, hbp};
    assign h_last   = h_total - XW'(1);
    assign hs_start = {1'b0, ha} + {1'b0, hfp};
    assign hs_end   = hs_start + {1'b0, hs};

    assign v_total  = {1'b0, va} + {1'b0, vfp} + {1'b0, vs} + {1'b0, vbp};
    assign v_last   = v_total - YW'(1);
    assign vs_start = {1'b0, va} + {1'b0, vfp};
    assign vs_end   = vs_start + {1'b0, vs};

    // ">=" rather than "==" so a counter stranded past a shrunken total still wraps
    assign line_end  = tick_q && ({1'b0, x_q} >= h_last);
    assign frame_end = line_end && ({1'b0, y_q} >= v_last);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (line_end) begin
            x_d = '0;
            y_d = frame_end ? '0 : y_q + YRES_BITS'(1);
        end else if (tick_q) begin
            x_d = x_q + XRES_BITS'(1);
        end
    end

    assign hs_act_d = ({1'b0, x_d} >= hs_start) && ({1'b0, x_d} < hs_end);
    assign vs_act_d = ({1'b0, y_d} >= vs_start) && ({1'b0, y_d} < vs_end);
    assign video_d  = (x_d < ha) && (y_d < va);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pclk_meta_q <= 1'b0;
            pclk_sync_q <= 1'b0;
            pclk_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            hsync_q     <= ~HSYNC_POLARITY;
            vsync_q     <= ~VSYNC_POLARITY;
            video_q     <= 1'b0;
        end else begin
            pclk_meta_q <= PixelClock;
            pclk_sync_q <= pclk_meta_q;
            pclk_prev_q <= pclk_sync_q;
            tick_q      <= pclk_prev_q & ~pclk_sync_q;
            x_q         <= x_d;
            y_q         <= y_d;
            // Decode tracks the coordinates, so it only moves on a tick
            if (tick_q) begin
                hsync_q <= hs_act_d ? HSYNC_POLARITY : ~HSYNC_POLARITY;
                vsync_q <= vs_act_d ? VSYNC_POLARITY : ~VSYNC_POLARITY;
                video_q <= video_d;
            end
        end
    end

    assign xposition = x_q;
    assign yposition = y_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign VideoOn   = video_q;
    assign PixelTick = tick_q;
    assign LineEnd   = line_end;
    assign FrameEnd  = frame_end;

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Parametrised VGA video timer producing horizontal and vertical sync, pixel coordinates, a display-enable flag and line/frame strobes from a single system clock and an unsynchronised pixel-rate reference. It is the two-axis successor to the single-axis hsync generator and feeds the game logic and the RGB output stage directly. Timing values are runtime inputs, so one instance covers 640x480 and reduced-size simulation modes.

## Interface
- XRES_BITS, 10, width of horizontal timing inputs and xposition
- YRES_BITS, 10, width of vertical timing inputs and yposition
- HSYNC_POLARITY, 0, active level of hsync (0 = active-low)
- VSYNC_POLARITY, 0, active level of vsync (0 = active-low)

- Clock  in  1  system clock; all state on rising edge
- Reset  in  1  synchronous, active-high
- PixelClock  in  1  pixel-rate reference, asynchronous to Clock
- HActive, HFrontPorch, HSynch, HBackPorch  in  XRES_BITS each  horizontal segment lengths in pixels
- VActive, VFrontPorch, VSynch, VBackPorch  in  YRES_BITS each  vertical segment lengths in lines
- xposition  out  XRES_BITS  current pixel column, 0..HTotal-1
- yposition  out  YRES_BITS  current line, 0..VTotal-1
- hsync, vsync  out  1  sync pulses at configured polarity
- VideoOn  out  1  high when xposition<HActive and yposition<VActive
- PixelTick  out  1  one-Clock pulse per PixelClock falling edge
- LineEnd  out  1  one-Clock pulse on the tick that wraps xposition
- FrameEnd  out  1  one-Clock pulse on the tick that wraps both counters

## Operation
- PixelClock passes a 2-flop synchroniser; a falling edge of the synchronised signal raises PixelTick for exactly one Clock cycle.
- Segment order per axis: Active, FrontPorch, Synch, BackPorch. HTotal = sum of horizontal inputs, computed in XRES_BITS+1 bits; VTotal likewise.
- On PixelTick: if xposition==HTotal-1, xposition<=0 and LineEnd pulses; else xposition+1.
- On a LineEnd tick: if yposition==VTotal-1, yposition<=0 and FrameEnd pulses; else yposition+1.
- hsync active for exactly HSynch pixels: HActive+HFrontPorch <= xposition < HActive+HFrontPorch+HSynch. vsync identical on the vertical axis in line units.
- Legal inputs: every Active and Synch >=1, HTotal<=2^XRES_BITS, VTotal<=2^YRES_BITS. Porches may be 0.
- If a counter is >= its current Total (inputs changed live), it wraps to 0 on the next tick with the corresponding strobe.

## Timing
- Reset: xposition=0, yposition=0, hsync=~HSYNC_POLARITY, vsync=~VSYNC_POLARITY, VideoOn=0, PixelTick=0, LineEnd=0, FrameEnd=0, synchroniser flops cleared.
- PixelClock falling edge to PixelTick: 2-3 Clock cycles (synchroniser phase). Counters update on the Clock edge at which PixelTick is high.
- hsync, vsync, VideoOn are registered and change on the same edge as the counters, consistent with the new coordinates (zero skew).
- LineEnd and FrameEnd are high in the cycle PixelTick is high and the counter is at its last value; they coincide with PixelTick.
- Reset asserted mid-line overrides a simultaneous PixelTick; first tick after release yields xposition=1.
- PixelClock must be at most Clock/4; faster input drops ticks (unchecked).

## Configuration
- VGA_TIMING_SHADOW_EN defined: all eight timing inputs captured into shadow registers on Reset and on each FrameEnd cycle; counters and sync decode use shadows only, so mid-frame input changes take effect from the next frame.
- Not defined: inputs used live; changes take effect on the next tick, wrap rule above applies.

## Test plan
- 640/16/96/48 x 480/10/2/33 -> HTotal 800, LineEnd every 800 ticks, hsync low for xposition 656..751, vsync low for yposition 490..491, FrameEnd every 420000 ticks.
- H 4/1/2/1, V 3/1/1/1 -> xposition 0..7 wraps, hsync low at 5,6 only, VideoOn high for x<4 and y<3, FrameEnd every 48 ticks.
- HSYNC_POLARITY=1 -> hsync high only for 656..751, low during reset.
- Reset asserted at xposition=300 with PixelTick -> next cycle all outputs at reset values; first tick gives xposition=1.
- HActive changed 640->320 at yposition=100: with VGA_TIMING_SHADOW_EN, line length stays 800 until FrameEnd, then 480; without, next tick at xposition>=480 wraps to 0 with LineEnd.
- PixelClock toggled with jitter (Clock/4 to Clock/10) -> exactly one PixelTick per falling edge, no missed or double ticks.
